// File: rtl/riscv_i32_fetch_debug_buffered.sv
// Fetch-side debug stage: forwards fetches in RUN. When halted it drains in-flight fetches,
// collects a program buffer from the debug module, and injects it into the pipeline.
module riscv_i32_fetch_debug_buffered #(
   parameter int         PROG_BUF_DEPTH  = 4,
   parameter int         MAX_OUTSTANDING = 3,
   parameter int         HALT_TIMEOUT    = 255,
   parameter logic [2:0] DEBUG_MODE      = 3'h4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pipeline_ifetch_req__valid,
   input  logic [31:0] pipeline_ifetch_req__address,
   input  logic        pipeline_ifetch_req__sequential,
   input  logic [2:0]  pipeline_ifetch_req__mode,
   input  logic        pipeline_ifetch_req__flush,
   output logic        pipeline_ifetch_resp__valid,
   output logic        pipeline_ifetch_resp__debug,
   output logic [31:0] pipeline_ifetch_resp__data,
   output logic [2:0]  pipeline_ifetch_resp__mode,
   output logic        pipeline_ifetch_resp__error,
   output logic [1:0]  pipeline_ifetch_resp__tag,
   output logic        ifetch_req__valid,
   output logic [31:0] ifetch_req__address,
   output logic        ifetch_req__sequential,
   output logic [2:0]  ifetch_req__mode,
   output logic        ifetch_req__flush,
   input  logic        ifetch_resp__valid,
   input  logic        ifetch_resp__debug,
   input  logic [31:0] ifetch_resp__data,
   input  logic [2:0]  ifetch_resp__mode,
   input  logic        ifetch_resp__error,
   input  logic [1:0]  ifetch_resp__tag,
   input  logic        debug_control__valid,
   input  logic        debug_control__kill_fetch,
   input  logic        debug_control__halt_request,
   input  logic        debug_control__fetch_dret,
   input  logic [31:0] debug_control__data,
   output logic        debug_response__valid,
   output logic        debug_response__kill_fetch,
   output logic        debug_response__halt_request,
   output logic        debug_response__fetch_dret,
   output logic [31:0] debug_response__data,
   input  logic        pipeline_trace__instr_valid,
   input  logic [31:0] pipeline_trace__instr_pc,
   input  logic        pipeline_trace__rfw_data_valid,
   input  logic [31:0] pipeline_trace__rfw_data,
   input  logic        pipeline_trace__trap
);

   localparam int AW = (PROG_BUF_DEPTH > 1) ? $clog2(PROG_BUF_DEPTH) : 1;
   localparam int CW = $clog2(PROG_BUF_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = $clog2(HALT_TIMEOUT + 1);
   localparam logic [CW-1:0] BUF_FULL  = CW'(PROG_BUF_DEPTH);
   localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(HALT_TIMEOUT);
   localparam logic [31:0]   EBREAK    = 32'h0010_0073;

   typedef enum logic [2:0] {RUN, HALT_WAIT, HALTED, INJECT, RESUME} state_t;

   state_t            state_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     rd_ptr_reg;
   logic [OW-1:0]     outstanding_reg;
   logic [OW-1:0]     outstanding_next;
   logic [TW-1:0]     tmo_reg;
   logic              force_flush_reg;
   logic [31:0]       last_pc_reg;
   logic [31:0]       last_rfw_reg;
   logic              inj_valid_reg;
   logic [31:0]       inj_data_reg;
   logic              rsp_valid_reg;
   logic              rsp_kill_reg;
   logic              rsp_halt_reg;
   logic              rsp_dret_reg;
   logic [31:0]       rsp_data_reg;
   logic [31:0]       buf_mem [PROG_BUF_DEPTH];
   logic              run;
   logic              cmd;
   logic              write;
   logic              buf_we;
   logic              drained;

   assign run    = (state_reg == RUN);
   assign cmd    = debug_control__valid;
   assign write  = cmd & ~debug_control__halt_request & ~debug_control__kill_fetch &
                   ~debug_control__fetch_dret;
   assign buf_we = (state_reg == HALTED) && write && (count_reg != BUF_FULL);

   assign ifetch_req__valid      = pipeline_ifetch_req__valid & run;
   assign ifetch_req__address    = pipeline_ifetch_req__address;
   assign ifetch_req__sequential = pipeline_ifetch_req__sequential;
   assign ifetch_req__mode       = pipeline_ifetch_req__mode;
   assign ifetch_req__flush      = pipeline_ifetch_req__flush | force_flush_reg;

   // An injected response already in flight is still delivered, whatever the state.
   assign pipeline_ifetch_resp__valid = inj_valid_reg | (run & ifetch_resp__valid);
   assign pipeline_ifetch_resp__debug = inj_valid_reg ? 1'b1         : ifetch_resp__debug;
   assign pipeline_ifetch_resp__data  = inj_valid_reg ? inj_data_reg : ifetch_resp__data;
   assign pipeline_ifetch_resp__mode  = inj_valid_reg ? DEBUG_MODE   : ifetch_resp__mode;
   assign pipeline_ifetch_resp__error = inj_valid_reg ? 1'b0         : ifetch_resp__error;
   assign pipeline_ifetch_resp__tag   = inj_valid_reg ? 2'b00        : ifetch_resp__tag;

   assign debug_response__valid        = rsp_valid_reg;
   assign debug_response__kill_fetch   = rsp_kill_reg;
   assign debug_response__halt_request = rsp_halt_reg;
   assign debug_response__fetch_dret   = rsp_dret_reg;
   assign debug_response__data         = rsp_data_reg;

   always_comb begin
      outstanding_next = outstanding_reg;
      if (ifetch_req__valid && !ifetch_resp__valid && outstanding_reg != OUT_MAX)
         outstanding_next = outstanding_reg + 1'b1;
      else if (!ifetch_req__valid && ifetch_resp__valid && outstanding_reg != '0)
         outstanding_next = outstanding_reg - 1'b1;
   end

   // Drain judged on the post-update count so the halt completes right after the last response.
   assign drained = (outstanding_next == '0);

   always_ff @(posedge clk) begin
      if (buf_we)
         buf_mem[count_reg[AW-1:0]] <= debug_control__data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= RUN;
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         outstanding_reg <= '0;
         tmo_reg         <= '0;
         force_flush_reg <= 1'b0;
         last_pc_reg     <= '0;
         last_rfw_reg    <= '0;
         inj_valid_reg   <= 1'b0;
         inj_data_reg    <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_kill_reg    <= 1'b0;
         rsp_halt_reg    <= 1'b0;
         rsp_dret_reg    <= 1'b0;
         rsp_data_reg    <= '0;
      end else begin
         rsp_valid_reg   <= 1'b0;
         rsp_kill_reg    <= 1'b0;
         rsp_halt_reg    <= 1'b0;
         rsp_dret_reg    <= 1'b0;
         rsp_data_reg    <= '0;
         inj_valid_reg   <= 1'b0;
         outstanding_reg <= outstanding_next;
         if (pipeline_trace__instr_valid)
            last_pc_reg <= pipeline_trace__instr_pc;
         if (pipeline_trace__rfw_data_valid)
            last_rfw_reg <= pipeline_trace__rfw_data;

         case (state_reg)
            RUN: begin
               if (ifetch_req__valid)
                  force_flush_reg <= 1'b0;
               if (cmd && debug_control__halt_request) begin
                  state_reg <= HALT_WAIT;
                  tmo_reg   <= '0;
               end
            end
            HALT_WAIT: begin
               if (drained || tmo_reg == TMO_LIMIT) begin
                  state_reg     <= HALTED;
                  rsp_valid_reg <= 1'b1;
                  rsp_halt_reg  <= 1'b1;
                  rsp_data_reg  <= drained ? last_pc_reg : 32'hFFFF_FFFF;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            HALTED: begin
               if (cmd && debug_control__fetch_dret) begin
                  state_reg <= RESUME;
               end else if (cmd && debug_control__kill_fetch) begin
                  state_reg  <= INJECT;
                  rd_ptr_reg <= '0;
               end else if (cmd && debug_control__halt_request) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_halt_reg  <= 1'b1;
                  rsp_data_reg  <= last_pc_reg;
               end else if (write) begin
                  rsp_valid_reg <= 1'b1;
                  if (count_reg == BUF_FULL) begin
                     rsp_data_reg <= 32'd1;
                  end else begin
                     count_reg <= count_reg + 1'b1;
                  end
               end
            end
            INJECT: begin
               if (pipeline_ifetch_req__valid) begin
                  inj_valid_reg <= 1'b1;
                  if (rd_ptr_reg < count_reg) begin
                     inj_data_reg <= buf_mem[rd_ptr_reg[AW-1:0]];
                     rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                  end else begin
                     inj_data_reg <= EBREAK;
                  end
               end
               if (pipeline_trace__instr_valid && pipeline_trace__trap) begin
                  state_reg     <= HALTED;
                  rsp_valid_reg <= 1'b1;
                  rsp_kill_reg  <= 1'b1;
                  rsp_data_reg  <= last_rfw_reg;
               end
            end
            RESUME: begin
               count_reg       <= '0;
               force_flush_reg <= 1'b1;
               rsp_valid_reg   <= 1'b1;
               rsp_dret_reg    <= 1'b1;
               rsp_data_reg    <= last_pc_reg;
               state_reg       <= RUN;
            end
            default: state_reg <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_i32_fetch_debug_buffered.sv
// Scoreboard bench: stimulus pushes expected memory requests, pipeline responses and debug pulses;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_riscv_i32_fetch_debug_buffered;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        p_req_valid, p_req_seq, p_req_flush;
   logic [31:0] p_req_addr;
   logic [2:0]  p_req_mode;
   logic        p_rsp_valid, p_rsp_debug, p_rsp_error;
   logic [31:0] p_rsp_data;
   logic [2:0]  p_rsp_mode;
   logic [1:0]  p_rsp_tag;
   logic        m_req_valid, m_req_seq, m_req_flush;
   logic [31:0] m_req_addr;
   logic [2:0]  m_req_mode;
   logic        m_rsp_valid, m_rsp_debug, m_rsp_error;
   logic [31:0] m_rsp_data;
   logic [2:0]  m_rsp_mode;
   logic [1:0]  m_rsp_tag;
   logic        dc_valid, dc_kill, dc_halt, dc_dret;
   logic [31:0] dc_data;
   logic        dr_valid, dr_kill, dr_halt, dr_dret;
   logic [31:0] dr_data;
   logic        tr_ivalid, tr_rfw_valid, tr_trap;
   logic [31:0] tr_pc, tr_rfw;

   int checks = 0;
   int errors = 0;

   typedef struct {logic [31:0] addr; logic [2:0] mode; logic flush;} req_t;
   typedef struct {logic debug; logic [31:0] data; logic [2:0] mode; logic error; logic [1:0] tag;} resp_t;
   typedef struct {logic kill; logic halt; logic dret; logic [31:0] data;} dbg_t;

   req_t  exp_req[$];
   resp_t exp_resp[$];
   dbg_t  exp_dbg[$];
   req_t  r;
   resp_t p;
   dbg_t  d;

   always #5 clk = ~clk;

   riscv_i32_fetch_debug_buffered dut (
      .clk(clk), .reset_n(reset_n),
      .pipeline_ifetch_req__valid(p_req_valid), .pipeline_ifetch_req__address(p_req_addr),
      .pipeline_ifetch_req__sequential(p_req_seq), .pipeline_ifetch_req__mode(p_req_mode),
      .pipeline_ifetch_req__flush(p_req_flush),
      .pipeline_ifetch_resp__valid(p_rsp_valid), .pipeline_ifetch_resp__debug(p_rsp_debug),
      .pipeline_ifetch_resp__data(p_rsp_data), .pipeline_ifetch_resp__mode(p_rsp_mode),
      .pipeline_ifetch_resp__error(p_rsp_error), .pipeline_ifetch_resp__tag(p_rsp_tag),
      .ifetch_req__valid(m_req_valid), .ifetch_req__address(m_req_addr),
      .ifetch_req__sequential(m_req_seq), .ifetch_req__mode(m_req_mode),
      .ifetch_req__flush(m_req_flush),
      .ifetch_resp__valid(m_rsp_valid), .ifetch_resp__debug(m_rsp_debug),
      .ifetch_resp__data(m_rsp_data), .ifetch_resp__mode(m_rsp_mode),
      .ifetch_resp__error(m_rsp_error), .ifetch_resp__tag(m_rsp_tag),
      .debug_control__valid(dc_valid), .debug_control__kill_fetch(dc_kill),
      .debug_control__halt_request(dc_halt), .debug_control__fetch_dret(dc_dret),
      .debug_control__data(dc_data),
      .debug_response__valid(dr_valid), .debug_response__kill_fetch(dr_kill),
      .debug_response__halt_request(dr_halt), .debug_response__fetch_dret(dr_dret),
      .debug_response__data(dr_data),
      .pipeline_trace__instr_valid(tr_ivalid), .pipeline_trace__instr_pc(tr_pc),
      .pipeline_trace__rfw_data_valid(tr_rfw_valid), .pipeline_trace__rfw_data(tr_rfw),
      .pipeline_trace__trap(tr_trap)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_req_valid) begin
         if (exp_req.size() == 0) begin
            chk("unexpected_mem_req", {32'd0, m_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            r = exp_req.pop_front();
            $display("mem req  addr=%h mode=%0d flush=%0d", m_req_addr, m_req_mode, m_req_flush);
            chk("mem_req", {28'd0, m_req_addr, m_req_mode, m_req_flush}, {28'd0, r.addr, r.mode, r.flush});
         end
      end
      if (p_rsp_valid) begin
         if (exp_resp.size() == 0) begin
            chk("unexpected_pipe_resp", {32'd0, p_rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            p = exp_resp.pop_front();
            $display("pipe rsp data=%h debug=%0d mode=%0d tag=%0d", p_rsp_data, p_rsp_debug, p_rsp_mode, p_rsp_tag);
            chk("pipe_resp", {25'd0, p_rsp_debug, p_rsp_data, p_rsp_mode, p_rsp_error, p_rsp_tag},
                {25'd0, p.debug, p.data, p.mode, p.error, p.tag});
         end
      end
      if (dr_valid) begin
         if (exp_dbg.size() == 0) begin
            chk("unexpected_dbg_pulse", {32'd0, dr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            d = exp_dbg.pop_front();
            $display("dbg rsp  kill=%0d halt=%0d dret=%0d data=%h", dr_kill, dr_halt, dr_dret, dr_data);
            chk("dbg_resp", {29'd0, dr_kill, dr_halt, dr_dret, dr_data}, {29'd0, d.kill, d.halt, d.dret, d.data});
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preq(input logic [31:0] a);
      p_req_valid = 1'b1; p_req_addr = a;
      cyc();
      p_req_valid = 1'b0;
   endtask

   task automatic mresp(input logic [31:0] dat, input logic [1:0] tag);
      m_rsp_valid = 1'b1; m_rsp_data = dat; m_rsp_tag = tag;
      cyc();
      m_rsp_valid = 1'b0;
   endtask

   task automatic dcmd(input logic k, input logic h, input logic r_, input logic [31:0] dat);
      dc_valid = 1'b1; dc_kill = k; dc_halt = h; dc_dret = r_; dc_data = dat;
      cyc();
      dc_valid = 1'b0; dc_kill = 1'b0; dc_halt = 1'b0; dc_dret = 1'b0;
   endtask

   task automatic reset_checks();
      chk("reset_dbg_valid", {63'd0, dr_valid}, 64'd0);
      chk("reset_dbg_data", {32'd0, dr_data}, 64'd0);
      chk("reset_pipe_valid", {63'd0, p_rsp_valid}, 64'd0);
   endtask

   logic [31:0] words [5];

   initial begin
      words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
      words[3] = 32'h4444_4444; words[4] = 32'h5555_5555;
      reset_n = 1'b0;
      p_req_valid = 0; p_req_addr = 0; p_req_seq = 1; p_req_mode = 3'd3; p_req_flush = 0;
      m_rsp_valid = 0; m_rsp_debug = 0; m_rsp_data = 0; m_rsp_mode = 3'd3; m_rsp_error = 0; m_rsp_tag = 0;
      dc_valid = 0; dc_kill = 0; dc_halt = 0; dc_dret = 0; dc_data = 0;
      tr_ivalid = 0; tr_pc = 0; tr_rfw_valid = 0; tr_rfw = 0; tr_trap = 0;
      cyc(2);
      reset_checks();
      reset_n = 1'b1;
      cyc();

      // RUN pass-through
      exp_req.push_back('{32'h100, 3'd3, 1'b0});
      preq(32'h100);
      exp_resp.push_back('{1'b0, 32'h13, 3'd3, 1'b0, 2'd1});
      mresp(32'h13, 2'd1);

      // Halt with two fetches in flight
      tr_ivalid = 1'b1; tr_pc = 32'h1FC;
      exp_req.push_back('{32'h200, 3'd3, 1'b0});
      preq(32'h200);
      tr_ivalid = 1'b0;
      exp_req.push_back('{32'h204, 3'd3, 1'b0});
      preq(32'h204);
      exp_dbg.push_back('{1'b0, 1'b1, 1'b0, 32'h1FC});
      dcmd(0, 1, 0, 0);
      preq(32'h208);
      mresp(32'hBAD0, 2'd0);
      mresp(32'hBAD1, 2'd0);
      cyc(3);

      // Program buffer: four accepted, fifth dropped
      for (int i = 0; i < 5; i++) begin
         exp_dbg.push_back('{1'b0, 1'b0, 1'b0, (i == 4) ? 32'd1 : 32'd0});
         dcmd(0, 0, 0, words[i]);
      end
      dcmd(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         exp_resp.push_back('{1'b1, (i < 4) ? words[i] : 32'h0010_0073, 3'd4, 1'b0, 2'd0});
         preq(32'h600 + 32'(4 * i));
      end

      // Trap retire ends execution
      tr_rfw_valid = 1'b1; tr_rfw = 32'hCAFE;
      cyc();
      tr_rfw_valid = 1'b0;
      exp_dbg.push_back('{1'b1, 1'b0, 1'b0, 32'hCAFE});
      tr_ivalid = 1'b1; tr_trap = 1'b1; tr_pc = 32'h800;
      cyc();
      tr_ivalid = 1'b0; tr_trap = 1'b0;
      cyc();
      exp_dbg.push_back('{1'b0, 1'b1, 1'b0, 32'h800});
      dcmd(0, 1, 0, 0);

      // dret together with kill_fetch: resume wins, first request flushed
      exp_dbg.push_back('{1'b0, 1'b0, 1'b1, 32'h800});
      dcmd(1, 0, 1, 0);
      cyc(2);
      exp_req.push_back('{32'h300, 3'd3, 1'b1});
      preq(32'h300);
      exp_req.push_back('{32'h304, 3'd3, 1'b0});
      preq(32'h304);
      exp_resp.push_back('{1'b0, 32'h33, 3'd3, 1'b0, 2'd2});
      mresp(32'h33, 2'd2);
      exp_resp.push_back('{1'b0, 32'h37, 3'd3, 1'b0, 2'd3});
      mresp(32'h37, 2'd3);

      // Halt timeout with a response that never returns
      exp_req.push_back('{32'h400, 3'd3, 1'b0});
      preq(32'h400);
      exp_dbg.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF});
      dcmd(0, 1, 0, 0);
      cyc(300);
      mresp(32'hDEAD, 2'd0);

      // Reset while injecting
      dcmd(1, 0, 0, 0);
      exp_resp.push_back('{1'b1, 32'h0010_0073, 3'd4, 1'b0, 2'd0});
      preq(32'h700);
      cyc(2);
      reset_n = 1'b0;
      cyc();
      reset_checks();
      reset_n = 1'b1;
      cyc();
      exp_req.push_back('{32'h500, 3'd3, 1'b0});
      preq(32'h500);
      exp_resp.push_back('{1'b0, 32'hDEAD_BEEF, 3'd3, 1'b0, 2'd1});
      mresp(32'hDEAD_BEEF, 2'd1);
      cyc(3);

      chk("req_queue_left", 64'(exp_req.size()), 64'd0);
      chk("resp_queue_left", 64'(exp_resp.size()), 64'd0);
      chk("dbg_queue_left", 64'(exp_dbg.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
